// File: rtl/immgen_pkg.sv
// immgen_pkg: shared opcodes, format codes and decoded-result type for the immediate generator.
// Contents: RV32I opcode constants, fmt_e format enum, imm_res_t {imm, fmt, invalido}.
// imm is carried at the widest supported XLEN (64) and truncated by the consumer.
package immgen_pkg;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam int IMM_W = 64;
   typedef enum logic [2:0] {
      FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
      FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6, FMT_NONE = 3'd7
   } fmt_e;
   typedef struct packed {
      logic [IMM_W-1:0] imm;
      fmt_e             fmt;
      logic             invalido;
   } imm_res_t;
endpackage

// File: rtl/immgen_pipe_if.sv
// immgen_pipe_if: valid/ready bundle between the decode front end and the immediate generator.
// Input side: in_valid, in_ready, instrucao. Output side: out_valid, out_ready,
// imediatoGerado (XLEN), formato (3), imm_invalido. slave = generator, master = its environment.
interface immgen_pipe_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instrucao;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imediatoGerado;
   logic [2:0]      formato;
   logic            imm_invalido;
   modport master (output in_valid, instrucao, out_ready,
                   input  in_ready, out_valid, imediatoGerado, formato, imm_invalido);
   modport slave  (input  in_valid, instrucao, out_ready,
                   output in_ready, out_valid, imediatoGerado, formato, imm_invalido);
endinterface

// File: rtl/immgen_decode.sv
// immgen_decode: combinational RV32I immediate decode of one instruction word.
// Ports: instr_i (32) raw instruction; res_o decoded {imm sign-extended to 64, fmt, invalido}.
// Shift-amount forms are zero-extended over SHAMT_W bits.
module immgen_decode
   import immgen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic [31:0] instr_i,
   output imm_res_t    res_o
);
   logic [2:0]       f3;
   fmt_e             fmt;
   logic [IMM_W-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;
   assign f3     = instr_i[14:12];
   assign i_imm  = {{52{instr_i[31]}}, instr_i[31:20]};
   assign s_imm  = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign b_imm  = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign u_imm  = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
   assign j_imm  = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
   assign sh_imm = IMM_W'(instr_i[20+SHAMT_W-1:20]);
   always_comb begin
      fmt = FMT_NONE;
      case (instr_i[6:0])
         OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
         OPC_OPIMM:                      fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
         OPC_STORE:                      fmt = FMT_S;
         OPC_BRANCH:                     fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
         OPC_JAL:                        fmt = FMT_J;
         OPC_OP:                         fmt = FMT_R;
         default:                        fmt = FMT_NONE;
      endcase
   end
   always_comb begin
      res_o.fmt      = fmt;
      res_o.invalido = fmt == FMT_NONE;
      res_o.imm      = fmt == FMT_I  ? i_imm  :
                       fmt == FMT_S  ? s_imm  :
                       fmt == FMT_B  ? b_imm  :
                       fmt == FMT_U  ? u_imm  :
                       fmt == FMT_J  ? j_imm  :
                       fmt == FMT_SH ? sh_imm : '0;
   end
endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generator with a two-entry (main + skid) output buffer.
// Ports: clock, reset (async active-low), flush (sync, drops all held beats), bus (slave side
// of immgen_pipe_if). in_ready comes straight from the skid valid register so there is no
// combinational path from out_ready back to in_ready.
module immgen_pipe
   import immgen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   immgen_pipe_if.slave  bus
);
   imm_res_t dec, main_q, main_d, skid_q, skid_d;
   logic     main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic     acc, drain, load;
   immgen_decode #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_dec (
      .instr_i (bus.instrucao),
      .res_o   (dec)
   );
   // main takes a new beat whenever it is empty or being consumed; skid has priority so order holds
   always_comb begin
      acc      = bus.in_valid && !skid_v_q;
      drain    = main_v_q && bus.out_ready;
      load     = !main_v_q || drain;
      main_d   = (load && skid_v_q) ? skid_q : (load && acc) ? dec : main_q;
      main_v_d = !flush && (!load || skid_v_q || acc);
      skid_d   = (acc && !load) ? dec : skid_q;
      skid_v_d = !flush && (skid_v_q ? !load : acc && !load);
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end
   assign bus.in_ready       = !skid_v_q;
   assign bus.out_valid      = main_v_q;
   assign bus.imediatoGerado = main_q.imm[XLEN-1:0];
   assign bus.formato        = main_q.fmt;
   assign bus.imm_invalido   = main_q.invalido;
   // upper immediate bits are pure sign copies when XLEN is narrower than the carried width
   if (XLEN < IMM_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^main_q.imm[IMM_W-1:XLEN];
   end
endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed + random checks of immgen_pipe at XLEN=32 and XLEN=64 against a queue scoreboard.
module tb_immgen_pipe;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   always #5 clock = ~clock;

   immgen_pipe_if #(.XLEN(32)) b32 ();
   immgen_pipe_if #(.XLEN(64)) b64 ();
   immgen_pipe #(.XLEN(32)) dut32 (.clock(clock), .reset(reset), .flush(flush), .bus(b32));
   immgen_pipe #(.XLEN(64)) dut64 (.clock(clock), .reset(reset), .flush(flush), .bus(b64));
   assign b64.in_valid  = b32.in_valid;
   assign b64.instrucao = b32.instrucao;
   assign b64.out_ready = b32.out_ready;

   int          n_cmp = 0;
   int          n_err = 0;
   int          delivered = 0;
   logic [31:0] q[$];
   logic        stall_q = 1'b0;
   logic [31:0] hold_imm;
   logic [2:0]  hold_fmt;
   logic        hold_inv;

   logic [31:0] dv_i   [8] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h123452B7,
                               32'h001000EF, 32'h41F0D093, 32'hFFFFFFFF, 32'h03F09093};
   logic [31:0] dv_e32 [8] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000,
                               32'h00000800, 32'h0000001F, 32'h00000000, 32'h0000001F};
   logic [63:0] dv_e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hC, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                               64'h800, 64'h1F, 64'h0, 64'h3F};
   int          dv_f   [8] = '{1, 2, 3, 4, 5, 6, 7, 6};
   logic [31:0] bp [6];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference immediate from the ISA field rules, using arithmetic shifts on the whole word
   function automatic logic [63:0] m_imm(input logic [31:0] i, input int xl);
      longint      s, hi;
      logic [63:0] r;
      s  = longint'($signed(i));
      hi = 0;
      case (i[6:0])
         7'h03, 7'h67, 7'h73: begin hi = s >>> 20; r = hi; end
         7'h13: begin
            hi = s >>> 20;
            r  = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 64'((i >> 20) & (xl == 64 ? 32'd63 : 32'd31)) : hi;
         end
         7'h23: begin hi = s >>> 25; r = (hi << 5) | 64'(i[11:7]); end
         7'h63: begin hi = s >>> 31; r = (hi << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1); end
         7'h37, 7'h17: r = s & ~64'hFFF;
         7'h6F: begin hi = s >>> 31; r = (hi << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1); end
         default: r = 64'd0;
      endcase
      return xl == 32 ? {32'd0, r[31:0]} : r;
   endfunction

   function automatic int m_fmt(input logic [31:0] i);
      case (i[6:0])
         7'h03, 7'h67, 7'h73: return 1;
         7'h13:               return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 6 : 1;
         7'h23:               return 2;
         7'h63:               return 3;
         7'h37, 7'h17:        return 4;
         7'h6F:               return 5;
         7'h33:               return 0;
         default:             return 7;
      endcase
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h73};
      logic [31:0] r;
      int          p;
      r = $urandom;
      p = $urandom_range(0, 11);
      if (p < 10) r[6:0] = ops[p];
      return r;
   endfunction

   // checks this cycle's outputs against the scoreboard, books handshakes, then advances one edge
   task automatic tick();
      logic [31:0] ins;
      chk("in_ready", 64'(b32.in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(b32.out_valid), 64'(q.size() > 0));
      chk("out_valid64", 64'(b64.out_valid), 64'(q.size() > 0));
      if (stall_q && b32.out_valid) begin
         chk("hold_imm", 64'(b32.imediatoGerado), 64'(hold_imm));
         chk("hold_fmt", 64'(b32.formato), 64'(hold_fmt));
         chk("hold_inv", 64'(b32.imm_invalido), 64'(hold_inv));
      end
      if (b32.out_valid && b32.out_ready && q.size() > 0) begin
         ins = q.pop_front();
         delivered++;
         chk("imm32", 64'(b32.imediatoGerado), m_imm(ins, 32));
         chk("fmt32", 64'(b32.formato), 64'(m_fmt(ins)));
         chk("inv32", 64'(b32.imm_invalido), 64'(m_fmt(ins) == 7));
         chk("imm64", b64.imediatoGerado, m_imm(ins, 64));
         chk("fmt64", 64'(b64.formato), 64'(m_fmt(ins)));
      end
      stall_q  = b32.out_valid && !b32.out_ready;
      hold_imm = b32.imediatoGerado;
      hold_fmt = b32.formato;
      hold_inv = b32.imm_invalido;
      if (b32.in_valid && b32.in_ready) q.push_back(b32.instrucao);
      if (flush) q.delete();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int sent, c, saw_full, d0;
      logic acc;
      b32.in_valid  = 1'b0;
      b32.instrucao = 32'd0;
      b32.out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_ov", 64'(b32.out_valid), 64'd0);
      chk("rst_imm", 64'(b32.imediatoGerado), 64'd0);
      chk("rst_fmt", 64'(b32.formato), 64'd0);
      chk("rst_inv", 64'(b32.imm_invalido), 64'd0);
      chk("rst_ir", 64'(b32.in_ready), 64'd1);
      chk("rst_imm64", b64.imediatoGerado, 64'd0);

      for (int k = 0; k < 8; k++) begin
         b32.in_valid  = 1'b1;
         b32.instrucao = dv_i[k];
         b32.out_ready = 1'b1;
         tick();
         b32.in_valid  = 1'b0;
         chk("tp_lat", 64'(b32.out_valid), 64'd1);
         chk("tp_imm32", 64'(b32.imediatoGerado), 64'(dv_e32[k]));
         chk("tp_imm64", b64.imediatoGerado, dv_e64[k]);
         chk("tp_fmt", 64'(b32.formato), 64'(dv_f[k]));
         chk("tp_inv", 64'(b32.imm_invalido), 64'(k == 6));
         tick();
      end

      for (int k = 0; k < 6; k++) bp[k] = rnd_instr();
      sent = 0; c = 0; saw_full = 0; d0 = delivered;
      while ((sent < 6 || q.size() > 0) && c < 40) begin
         b32.in_valid  = sent < 6;
         b32.instrucao = sent < 6 ? bp[sent] : 32'd0;
         b32.out_ready = !(c >= 2 && c <= 4);
         acc = b32.in_valid && b32.in_ready;
         if (!b32.in_ready) saw_full++;
         tick();
         if (acc) sent++;
         c++;
      end
      b32.in_valid = 1'b0;
      chk("bp_sent", 64'(sent), 64'd6);
      chk("bp_full_seen", 64'(saw_full > 0), 64'd1);
      chk("bp_delivered", 64'(delivered - d0), 64'd6);

      b32.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         b32.in_valid  = 1'b1;
         b32.instrucao = rnd_instr();
         tick();
      end
      chk("fl_full", 64'(b32.in_ready), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      b32.in_valid = 1'b0;
      chk("fl_ov", 64'(b32.out_valid), 64'd0);
      chk("fl_ir", 64'(b32.in_ready), 64'd1);
      b32.in_valid  = 1'b1;
      b32.instrucao = 32'h0000A0B7;
      tick();
      flush = 1'b1;
      b32.instrucao = 32'hFFF00093;
      b32.out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl2_ov", 64'(b32.out_valid), 64'd0);
      b32.instrucao = 32'h00112623;
      tick();
      b32.in_valid = 1'b0;
      chk("fl_next_ov", 64'(b32.out_valid), 64'd1);
      chk("fl_next_imm", 64'(b32.imediatoGerado), 64'hC);
      tick();

      b32.in_valid  = 1'b1;
      b32.instrucao = 32'h123452B7;
      b32.out_ready = 1'b0;
      tick();
      b32.in_valid = 1'b0;
      chk("rs_ov_pre", 64'(b32.out_valid), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("rs_ov", 64'(b32.out_valid), 64'd0);
      chk("rs_imm", 64'(b32.imediatoGerado), 64'd0);
      chk("rs_fmt", 64'(b32.formato), 64'd0);
      chk("rs_inv", 64'(b32.imm_invalido), 64'd0);
      chk("rs_imm64", b64.imediatoGerado, 64'd0);
      q.delete();
      stall_q = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      b32.in_valid  = 1'b1;
      b32.instrucao = 32'h001000EF;
      b32.out_ready = 1'b1;
      tick();
      b32.in_valid = 1'b0;
      chk("rs_lat", 64'(b32.out_valid), 64'd1);
      chk("rs_new_imm", 64'(b32.imediatoGerado), 64'h800);
      tick();

      for (int k = 0; k < 400; k++) begin
         b32.in_valid  = $urandom_range(0, 3) != 0;
         b32.instrucao = rnd_instr();
         b32.out_ready = $urandom_range(0, 3) != 0;
         flush         = $urandom_range(0, 19) == 0;
         tick();
      end
      flush        = 1'b0;
      b32.in_valid = 1'b0;
      b32.out_ready = 1'b1;
      repeat (3) tick();
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
